// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier generating a clean system reset.
// Optional lock-loss counter enabled by defining PLLSUP_LOSS_COUNT_EN.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    localparam int RW = $clog2(MAX_RETRIES + 1)
) (
    input  logic          refclk,
    input  logic          rst_n,
    input  logic          pll_locked,
    input  logic          force_relock,
    output logic          pll_rst,
    output logic          sys_rst,
    output logic          ready,
    output logic          fail,
    output logic [RW-1:0] retry_cnt
`ifdef PLLSUP_LOSS_COUNT_EN
    ,
    output logic [7:0]    loss_cnt
`endif
);

    localparam int M1   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAXC = (M1 > STABLE_CYCLES) ? M1 : STABLE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE_CHK,
        RUN,
        FAIL
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry_nx;
    logic [1:0]    sync_q;
    logic          locked_s;

    assign locked_s = sync_q[1];

    // Two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], pll_locked};
    end

    // Next-state and retry bookkeeping; force_relock overrides everything
    always_comb begin
        state_nx = state;
        retry_nx = retry_cnt;
        case (state)
            RESET_PLL: begin
                if (cnt == CW'(RST_CYCLES - 1)) state_nx = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nx = STABLE_CHK;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    if (retry_cnt == RW'(MAX_RETRIES)) begin
                        state_nx = FAIL;
                    end else begin
                        retry_nx = retry_cnt + 1'b1;
                        state_nx = RESET_PLL;
                    end
                end
            end
            STABLE_CHK: begin
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    state_nx = RUN;
                    retry_nx = '0;
                end
            end
            RUN: begin
                if (!locked_s) state_nx = RESET_PLL;
            end
            FAIL: begin
                state_nx = FAIL;
            end
            default: begin
                state_nx = RESET_PLL;
            end
        endcase
        if (force_relock) begin
            state_nx = RESET_PLL;
            retry_nx = '0;
        end
    end

    // State, shared cycle counter and registered outputs
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nx;
            retry_cnt <= retry_nx;
            if (force_relock || (state_nx != state)) begin
                cnt <= '0;
            end else if (state != RUN && state != FAIL) begin
                cnt <= cnt + 1'b1;
            end
            pll_rst <= (state_nx == RESET_PLL) || (state_nx == FAIL);
            sys_rst <= (state_nx != RUN);
            ready   <= (state_nx == RUN);
            fail    <= (state_nx == FAIL);
        end
    end

`ifdef PLLSUP_LOSS_COUNT_EN
    logic loss_ev;

    assign loss_ev = (state == RUN) && !locked_s && !force_relock;

    // Saturating count of lock losses seen while running
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt <= 8'd0;
        end else if (loss_ev && loss_cnt != 8'hff) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
// Define PLLSUP_LOSS_COUNT_EN for both files to cover the loss counter.
module tb_pll_lock_supervisor;

    localparam int RW = 2;

    logic          refclk = 1'b0;
    logic          rst_n;
    logic          pll_locked;
    logic          force_relock;
    logic          pll_rst;
    logic          sys_rst;
    logic          ready;
    logic          fail;
    logic [RW-1:0] retry_cnt;
`ifdef PLLSUP_LOSS_COUNT_EN
    logic [7:0]    loss_cnt;
    logic [7:0]    exp_loss;
`endif

    int nvec = 0;
    int nerr = 0;

    pll_lock_supervisor #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .force_relock(force_relock),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fail        (fail),
        .retry_cnt   (retry_cnt)
`ifdef PLLSUP_LOSS_COUNT_EN
        ,
        .loss_cnt    (loss_cnt)
`endif
    );

    always #5 refclk = ~refclk;

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pll_rst"}, 32'(pll_rst), 32'd1);
        chk({tag, ".sys_rst"}, 32'(sys_rst), 32'd1);
        chk({tag, ".ready"}, 32'(ready), 32'd0);
        chk({tag, ".fail"}, 32'(fail), 32'd0);
        chk({tag, ".retry"}, 32'(retry_cnt), 32'd0);
`ifdef PLLSUP_LOSS_COUNT_EN
        chk({tag, ".loss"}, 32'(loss_cnt), 32'd0);
`endif
    endtask

    initial begin
        rst_n        = 1'b0;
        pll_locked   = 1'b0;
        force_relock = 1'b0;
        tick(3);
        chk_reset("rst0");
        rst_n = 1'b1;

        // normal lock: pll_locked rises after cycle 10
        tick(3);
        chk("nl.prst3", 32'(pll_rst), 32'd1);
        tick(1);
        chk("nl.prst4", 32'(pll_rst), 32'd0);
        tick(6);
        pll_locked = 1'b1;
        tick(10);
        chk("nl.rdy20", 32'(ready), 32'd0);
        chk("nl.srst20", 32'(sys_rst), 32'd1);
        tick(1);
        chk("nl.rdy21", 32'(ready), 32'd1);
        chk("nl.srst21", 32'(sys_rst), 32'd0);
        chk("nl.retry", 32'(retry_cnt), 32'd0);

        // one-cycle lock loss in RUN
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        chk("ls.rdy2", 32'(ready), 32'd1);
        tick(1);
        chk("ls.rdy3", 32'(ready), 32'd0);
        chk("ls.prst3", 32'(pll_rst), 32'd1);
        chk("ls.srst3", 32'(sys_rst), 32'd1);
        tick(3);
        chk("ls.prst6", 32'(pll_rst), 32'd1);
        tick(1);
        chk("ls.prst7", 32'(pll_rst), 32'd0);
        tick(8);
        chk("ls.rdy15", 32'(ready), 32'd0);
        tick(1);
        chk("ls.rdy16", 32'(ready), 32'd1);
`ifdef PLLSUP_LOSS_COUNT_EN
        chk("ls.loss", 32'(loss_cnt), 32'd1);
        for (int i = 0; i < 259; i++) begin
            pll_locked = 1'b0;
            tick(1);
            pll_locked = 1'b1;
            tick(15);
        end
        exp_loss = 8'd255;
        chk("sat.loss", 32'(loss_cnt), 32'(exp_loss));
        chk("sat.rdy", 32'(ready), 32'd1);
`endif

        // force_relock while running
        force_relock = 1'b1;
        tick(1);
        force_relock = 1'b0;
        chk("fr.prst", 32'(pll_rst), 32'd1);
        chk("fr.rdy", 32'(ready), 32'd0);
        chk("fr.srst", 32'(sys_rst), 32'd1);
`ifdef PLLSUP_LOSS_COUNT_EN
        chk("fr.loss", 32'(loss_cnt), 32'(exp_loss));
`endif
        tick(3);
        chk("fr.prst3", 32'(pll_rst), 32'd1);
        tick(1);
        chk("fr.prst4", 32'(pll_rst), 32'd0);
        tick(9);
        chk("fr.rdy13", 32'(ready), 32'd1);

        // force_relock coincident with synchronized lock loss
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        chk("fl.rdy2", 32'(ready), 32'd1);
        force_relock = 1'b1;
        tick(1);
        force_relock = 1'b0;
        chk("fl.prst", 32'(pll_rst), 32'd1);
        chk("fl.rdy", 32'(ready), 32'd0);
`ifdef PLLSUP_LOSS_COUNT_EN
        chk("fl.loss", 32'(loss_cnt), 32'(exp_loss));
`endif
        tick(13);
        chk("fl.rdy13", 32'(ready), 32'd1);

        // glitchy lock: 5 high, 1 low, then high
        pll_locked   = 1'b0;
        force_relock = 1'b1;
        tick(1);
        force_relock = 1'b0;
        tick(5);
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(5);
        chk("gl.rdy16", 32'(ready), 32'd0);
        tick(5);
        chk("gl.rdy21", 32'(ready), 32'd0);
        tick(1);
        chk("gl.rdy22", 32'(ready), 32'd1);
        chk("gl.retry", 32'(retry_cnt), 32'd0);

        // lock never arrives: three timeouts then FAIL
        pll_locked   = 1'b0;
        force_relock = 1'b1;
        tick(1);
        force_relock = 1'b0;
        tick(35);
        chk("to.retry35", 32'(retry_cnt), 32'd0);
        chk("to.prst35", 32'(pll_rst), 32'd0);
        tick(1);
        chk("to.retry36", 32'(retry_cnt), 32'd1);
        chk("to.prst36", 32'(pll_rst), 32'd1);
        tick(36);
        chk("to.retry72", 32'(retry_cnt), 32'd2);
        tick(35);
        chk("to.fail107", 32'(fail), 32'd0);
        tick(1);
        chk("to.fail108", 32'(fail), 32'd1);
        chk("to.prst108", 32'(pll_rst), 32'd1);
        chk("to.srst108", 32'(sys_rst), 32'd1);
        chk("to.rdy108", 32'(ready), 32'd0);
        chk("to.retry108", 32'(retry_cnt), 32'd2);
        tick(20);
        chk("to.hold", 32'(fail), 32'd1);

        // force_relock out of FAIL
        force_relock = 1'b1;
        tick(1);
        force_relock = 1'b0;
        chk("fx.fail", 32'(fail), 32'd0);
        chk("fx.retry", 32'(retry_cnt), 32'd0);
        chk("fx.prst", 32'(pll_rst), 32'd1);
        tick(3);
        chk("fx.prst3", 32'(pll_rst), 32'd1);
        tick(1);
        chk("fx.prst4", 32'(pll_rst), 32'd0);

        // async reset while in STABLE_CHK
        pll_locked = 1'b1;
        tick(5);
        chk("ar.prst", 32'(pll_rst), 32'd0);
        chk("ar.rdy", 32'(ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("ar");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
